// File: rtl/sram_scan_responder.sv
// Serial scan front end for the OpenRAM macro array: shift in a 112-bit command frame, drive one access, reload read data for shift-out.
// Optional feature macro SRAM_SCAN_ERR_EN adds the frame-length counter and the sticky frame_err_o checks.
module sram_scan_responder #(
  parameter int NUM_SRAM = 16,
  parameter int ADDR_W   = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   scan_en_i,
  input  logic                   scan_in_i,
  output logic                   scan_out_o,
  input  logic                   sram_load_i,
  input  logic                   global_csb_i,
  output logic [NUM_SRAM-1:0]    sram_sel_o,
  output logic                   csb0_o,
  output logic                   web0_o,
  output logic [3:0]             wmask0_o,
  output logic [ADDR_W-1:0]      addr0_o,
  output logic [31:0]            din0_o,
  output logic                   csb1_o,
  output logic                   web1_o,
  output logic [3:0]             wmask1_o,
  output logic [ADDR_W-1:0]      addr1_o,
  output logic [31:0]            din1_o,
  input  logic [NUM_SRAM*32-1:0] dout0_i,
  input  logic [NUM_SRAM*32-1:0] dout1_i,
  output logic                   frame_err_o
);

  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] addr0;
    logic [31:0] din0;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [15:0] addr1;
    logic [31:0] din1;
    logic        csb1;
    logic        web1;
    logic [3:0]  wmask1;
  } frame_t;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_READY} state_e;

  frame_t      sr_q, sr_d;
  state_e      state_q;
  logic [31:0] dout0_q, dout1_q;
  logic [3:0]  sel_q;
  logic        sel_ok_q, acc_csb0_q, acc_csb1_q;

  logic                strobe, frame_full, sel_ok, live, acc_en, shift, load;
  logic [NUM_SRAM-1:0] sel_oh;
  logic [31:0]         rd0, rd1;

  assign strobe = !global_csb_i && !scan_en_i && !wb_rst_i &&
                  (state_q == S_IDLE || state_q == S_READY);
  assign sel_ok = int'(sr_q.sel) < NUM_SRAM;
  assign live   = strobe && frame_full;
  assign shift  = scan_en_i && !sram_load_i;
  // A live strobe in READY takes precedence over a simultaneous load.
  assign load   = sram_load_i && state_q == S_READY && !live;

`ifdef SRAM_SCAN_ERR_EN
  logic [6:0] bit_cnt_q;
  logic       scan_en_prev_q, err_q;

  assign frame_full  = bit_cnt_q == 7'd112;
  assign acc_en      = live && sel_ok;
  assign frame_err_o = err_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bit_cnt_q      <= '0;
      scan_en_prev_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      scan_en_prev_q <= scan_en_i;
      if (shift) begin
        if (!scan_en_prev_q)            bit_cnt_q <= 7'd1;
        else if (bit_cnt_q != 7'd112)   bit_cnt_q <= bit_cnt_q + 7'd1;
      end
      if ((strobe && !(frame_full && sel_ok)) ||
          (sram_load_i && state_q != S_READY) ||
          (scan_en_i && state_q == S_ACCESS))
        err_q <= 1'b1;
    end
  end
`else
  assign frame_full  = 1'b1;
  assign acc_en      = live;
  assign frame_err_o = 1'b0;
`endif

  always_comb begin
    sel_oh = '0;
    for (int k = 0; k < NUM_SRAM; k++) sel_oh[k] = (int'(sr_q.sel) == k);
  end

  always_comb begin
    rd0 = '0;
    rd1 = '0;
    for (int k = 0; k < NUM_SRAM; k++) begin
      if (int'(sel_q) == k) begin
        rd0 = dout0_i[k*32 +: 32];
        rd1 = dout1_i[k*32 +: 32];
      end
    end
  end

  assign sram_sel_o = live ? sel_oh : '0;
  assign csb0_o     = acc_en ? sr_q.csb0 : 1'b1;
  assign csb1_o     = acc_en ? sr_q.csb1 : 1'b1;
  assign web0_o     = sr_q.web0;
  assign wmask0_o   = sr_q.wmask0;
  assign addr0_o    = sr_q.addr0[ADDR_W-1:0];
  assign din0_o     = sr_q.din0;
  assign web1_o     = sr_q.web1;
  assign wmask1_o   = sr_q.wmask1;
  assign addr1_o    = sr_q.addr1[ADDR_W-1:0];
  assign din1_o     = sr_q.din1;
  assign scan_out_o = sr_q.sel[3];

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d.din0 = dout0_q;
      sr_d.din1 = dout1_q;
    end else if (shift) begin
      sr_d = frame_t'({sr_q[110:0], scan_in_i});
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sr_q       <= '0;
      state_q    <= S_IDLE;
      dout0_q    <= '0;
      dout1_q    <= '0;
      sel_q      <= '0;
      sel_ok_q   <= 1'b0;
      acc_csb0_q <= 1'b1;
      acc_csb1_q <= 1'b1;
    end else begin
      sr_q <= sr_d;
      unique case (state_q)
        S_IDLE, S_READY: begin
          if (live) begin
            state_q    <= S_ACCESS;
            sel_q      <= sr_q.sel;
            sel_ok_q   <= sel_ok;
            acc_csb0_q <= csb0_o;
            acc_csb1_q <= csb1_o;
          end else if (load) begin
            state_q <= S_IDLE;
          end
        end
        S_ACCESS: begin
          state_q <= S_READY;
          // No macro answers an out-of-range select, so read-back is forced to zero.
          if (!sel_ok_q) begin
            dout0_q <= '0;
            dout1_q <= '0;
          end else begin
            if (!acc_csb0_q) dout0_q <= rd0;
            if (!acc_csb1_q) dout1_q <= rd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_scan_responder.sv
// Scoreboard bench for sram_scan_responder: driver queues expected access and read-back frames, monitor checks them.
module tb_sram_scan_responder;
  localparam int NS = 12;
  localparam int AW = 16;
`ifdef SRAM_SCAN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scan_en = 1'b0, scan_in = 1'b0, sram_load = 1'b0, gcsb = 1'b1;
  logic scan_out, csb0, web0, csb1, web1, ferr;
  logic [NS-1:0]    sel;
  logic [3:0]       wm0, wm1;
  logic [AW-1:0]    a0, a1;
  logic [31:0]      d0, d1;
  logic [NS*32-1:0] dout0, dout1;
  logic [31:0]      mem [NS][16];

  int n_chk = 0;
  int n_fail = 0;
  logic [119:0] acc_q[$];
  logic [111:0] rb_q[$];
  logic [111:0] exp_sr = '0;
  logic         unloading = 1'b0;
  logic [111:0] rb_sh = '0;
  int           rb_n = 0;

  always #5 clk = ~clk;

  sram_scan_responder #(.NUM_SRAM(NS), .ADDR_W(AW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .scan_en_i(scan_en), .scan_in_i(scan_in),
    .scan_out_o(scan_out), .sram_load_i(sram_load), .global_csb_i(gcsb),
    .sram_sel_o(sel), .csb0_o(csb0), .web0_o(web0), .wmask0_o(wm0), .addr0_o(a0),
    .din0_o(d0), .csb1_o(csb1), .web1_o(web1), .wmask1_o(wm1), .addr1_o(a1),
    .din1_o(d1), .dout0_i(dout0), .dout1_i(dout1), .frame_err_o(ferr)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [111:0] mk(input logic [3:0] s, input logic [15:0] ad0,
      input logic [31:0] dd0, input logic c0, input logic w0, input logic [3:0] m0,
      input logic [15:0] ad1, input logic [31:0] dd1, input logic c1, input logic w1,
      input logic [3:0] m1);
    return {s, ad0, dd0, c0, w0, m0, ad1, dd1, c1, w1, m1};
  endfunction

  function automatic logic [119:0] acc_vec(input logic [NS-1:0] s, input logic c0,
      input logic c1, input logic [111:0] f);
    return {s, c0, f[58], f[57:54], f[107:92], f[91:60], c1, f[4], f[3:0], f[53:38], f[37:6]};
  endfunction

  // Behavioural macro array: acts on what the DUT presents for the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < NS; k++)
        for (int a = 0; a < 16; a++) mem[k][a] <= '0;
      mem[0][2] <= 32'hFFFF_FFFF;
      dout0 <= '0;
      dout1 <= '0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (sel[k] && !csb0) begin
          if (!web0) begin
            for (int b = 0; b < 4; b++)
              if (wm0[b]) mem[k][a0[3:0]][8*b +: 8] <= d0[8*b +: 8];
          end else dout0[k*32 +: 32] <= mem[k][a0[3:0]];
        end
        if (sel[k] && !csb1) begin
          if (!web1) begin
            for (int b = 0; b < 4; b++)
              if (wm1[b]) mem[k][a1[3:0]][8*b +: 8] <= d1[8*b +: 8];
          end else dout1[k*32 +: 32] <= mem[k][a1[3:0]];
        end
      end
    end
  end

  // Monitor: strobe cycles pop the access queue, shift-out windows pop the read-back queue.
  always @(negedge clk) begin
    if (!gcsb && !scan_en && !rst) begin
      if (acc_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL access: unexpected strobe, no expectation queued");
      end else begin
        chk("access", 128'({sel, csb0, web0, wm0, a0, d0, csb1, web1, wm1, a1, d1}),
            128'(acc_q.pop_front()));
      end
    end
    if (unloading && scan_en) begin
      rb_sh = {rb_sh[110:0], scan_out};
      rb_n++;
      if (rb_n == 112) begin
        rb_n = 0;
        if (rb_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL readback: frame %0h with no expectation", rb_sh);
        end else chk("readback", 128'(rb_sh), 128'(rb_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [111:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      scan_en = 1'b1;
      scan_in = f[111-i];
      exp_sr  = {exp_sr[110:0], f[111-i]};
      tick();
    end
    scan_en = 1'b0;
    scan_in = 1'b0;
  endtask

  task automatic strobe(input logic [NS-1:0] s, input logic c0, input logic c1);
    acc_q.push_back(acc_vec(s, c0, c1, exp_sr));
    gcsb = 1'b0;
    tick();
    gcsb = 1'b1;
    #1;
    chk("post_strobe_sel", 128'(sel), 128'(0));
    chk("post_strobe_csb", 128'({csb0, csb1}), 128'(2'b11));
  endtask

  task automatic unload(input logic [111:0] exp);
    rb_q.push_back(exp);
    unloading = 1'b1;
    shift_bits(112'd0, 112);
    unloading = 1'b0;
  endtask

  task automatic load_unload(input logic [111:0] exp);
    sram_load = 1'b1;
    tick();
    sram_load = 1'b0;
    exp_sr = exp;
    unload(exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [111:0] f;
    gcsb = 1'b0;
    tick(); tick();
    chk("rst_active_csb", 128'({csb0, csb1}), 128'(2'b11));
    chk("rst_active_sel", 128'(sel), 128'(0));
    gcsb = 1'b1;
    rst  = 1'b0;
    #1;
    chk("rst_scan_out", 128'(scan_out), 128'(0));
    chk("rst_err", 128'(ferr), 128'(0));
    chk("rst_csb", 128'({csb0, csb1}), 128'(2'b11));

    // Write 2 to macro 2 addr 1, then read it back.
    f = mk(4'd2, 16'd1, 32'd2, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0);
    shift_bits(f, 112);
    strobe(12'h004, 1'b0, 1'b1);
    tick();
    f = mk(4'd2, 16'd1, 32'd0, 1'b0, 1'b1, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0);
    shift_bits(f, 112);
    strobe(12'h004, 1'b0, 1'b1);
    tick();
    load_unload(mk(4'd2, 16'd1, 32'd2, 1'b0, 1'b1, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0));

    // Dual-port read of macro 0.
    f = mk(4'd0, 16'd1, 32'h1234_5678, 1'b0, 1'b1, 4'hF, 16'd2, 32'hABCD_EF01, 1'b0, 1'b1, 4'hF);
    shift_bits(f, 112);
    strobe(12'h001, 1'b0, 1'b0);
    tick();
    load_unload(mk(4'd0, 16'd1, 32'd0, 1'b0, 1'b1, 4'hF, 16'd2, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'hF));
    chk("err_after_good_reads", 128'(ferr), 128'(0));

    // Out-of-range select reads back zeros.
    f = mk(4'd15, 16'd3, 32'h55, 1'b0, 1'b1, 4'hF, 16'd4, 32'h66, 1'b0, 1'b1, 4'hF);
    shift_bits(f, 112);
    strobe(12'h000, ERR_EN, ERR_EN);
    tick();
    load_unload(mk(4'd15, 16'd3, 32'd0, 1'b0, 1'b1, 4'hF, 16'd4, 32'd0, 1'b0, 1'b1, 4'hF));
    chk("err_sel_range", 128'(ferr), 128'(ERR_EN));

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    exp_sr = '0;
    #1;
    chk("err_cleared_by_reset", 128'(ferr), 128'(0));

    // Strobe after only 50 bits: sr holds 50 ones in its low bits.
    f = {50'h3_FFFF_FFFF_FFFF, 62'd0};
    shift_bits(f, 50);
    strobe(ERR_EN ? 12'h000 : 12'h001, ERR_EN, 1'b1);
    tick();
    chk("err_short_frame", 128'(ferr), 128'(ERR_EN));

    // Reset during the ACCESS cycle.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_sr = '0;
    f = mk(4'd3, 16'd7, 32'h11, 1'b0, 1'b1, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0);
    shift_bits(f, 112);
    strobe(12'h008, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_sr = '0;
    #1;
    chk("abort_scan_out", 128'(scan_out), 128'(0));
    chk("abort_csb", 128'({csb0, csb1}), 128'(2'b11));
    chk("abort_sel", 128'(sel), 128'(0));
    chk("abort_err", 128'(ferr), 128'(0));
    f = mk(4'd1, 16'd5, 32'hCAFE_BABE, 1'b1, 1'b1, 4'h0, 16'd6, 32'h0BAD_F00D, 1'b1, 1'b1, 4'h0);
    shift_bits(f, 112);
    sram_load = 1'b1;
    tick();
    sram_load = 1'b0;
    #1;
    chk("err_load_in_idle", 128'(ferr), 128'(ERR_EN));
    unload(f);

    tick(); tick();
    chk("acc_q_drained", 128'(acc_q.size()), 128'(0));
    chk("rb_q_drained", 128'(rb_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_scan_responder.md
# sram_scan_responder

On-chip responder for the serial SRAM test-scan protocol used in the user project. It shifts in a 112-bit command frame from the scan pins and decodes it into port-0/port-1 accesses on one of `NUM_SRAM` OpenRAM macros. It then captures the read data and reloads it into the scan register so the host can shift it back out. It sits in the user project wrapper between the `mprj_io` scan pins and the SRAM macro array.

## Interface
- `NUM_SRAM`, 16: number of SRAM macros addressable by the 4-bit `sel` field.
- `ADDR_W`, 16: macro address width; the low `ADDR_W` bits of each 16-bit frame address are used.
- `wb_clk_i`  in  1  sole clock; all scan inputs are synchronous to it.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `scan_en_i`  in  1  high: shift one bit per cycle.
- `scan_in_i`  in  1  serial frame data, MSB first.
- `scan_out_o`  out  1  equals `sr[111]` (combinational from register).
- `sram_load_i`  in  1  high: load captured dout into the scan register.
- `global_csb_i`  in  1  active-low access strobe, one cycle.
- `sram_sel_o`  out  NUM_SRAM  one-hot macro select, valid only during an access.
- `csb0_o`, `web0_o`  out  1  port-0 chip/write select (active low).
- `wmask0_o`  out  4, `addr0_o`  out  ADDR_W, `din0_o`  out  32  port-0 fields.
- `csb1_o`, `web1_o`, `wmask1_o`, `addr1_o`, `din1_o`  out  port-1 equivalents.
- `dout0_i`, `dout1_i`  in  NUM_SRAM*32  per-macro read data, where macro k uses bits [32k+31:32k].
- `frame_err_o`  out  1  sticky protocol error.

## Operation
- Frame layout in `sr[111:0]`:
  - sel[111:108], addr0[107:92], din0[91:60], csb0[59], web0[58], wmask0[57:54]
  - addr1[53:38], din1[37:6], csb1[5], web1[4], wmask1[3:0]
- Shift: when `scan_en_i=1`, `sr <= {sr[110:0], scan_in_i}`. Shift-in and shift-out are concurrent.
- `bit_cnt` (7 bits):
  - Clears on the first `scan_en_i=1` cycle after a cycle with `scan_en_i=0`; that cycle counts as 1.
  - Increments on each shift and saturates at 112.
  - `frame_full = (bit_cnt==112)`.
- Access is live when `global_csb_i=0`, `scan_en_i=0`, `wb_rst_i=0`, state is IDLE or READY, and `frame_full` is set. While live:
  - `csbN_o = sr.csbN`.
  - `sram_sel_o = 1<<sel`.
- Outside a live access: `csb0_o=csb1_o=1` and `sram_sel_o=0`. Data, address and mask outputs always follow `sr` fields.
- FSM states: IDLE, ACCESS, READY.
  - IDLE → ACCESS when the access is live (the macro samples at this edge).
  - ACCESS → READY at the next edge: `dout0_q/dout1_q <= dout0_i/dout1_i` slice selected by the latched sel. `dout0_q` is captured only if csb0 was 0, and likewise for port 1; otherwise the held value is kept.
  - READY with `sram_load_i=1` → IDLE: `sr.din0 <= dout0_q`, `sr.din1 <= dout1_q`, all other fields kept.
  - READY with a new strobe → ACCESS, same as IDLE.
- Errors: `frame_err_o` is set, and the access is suppressed, in each of these cases:
  - strobe with `frame_full=0`;
  - strobe with `sel >= NUM_SRAM`, in which case `sram_sel_o=0` and the captured dout is 0;
  - `sram_load_i` in IDLE or ACCESS, which is otherwise ignored;
  - `scan_en_i=1` during ACCESS (shift still occurs).
  - `frame_err_o` is cleared only by reset.
- Simultaneous `scan_en_i` and `sram_load_i`: load wins and no shift occurs.

## Timing
- Reset values:
  - `sr`=0, `scan_out_o`=0, `bit_cnt`=0, state IDLE, `dout*_q`=0, `frame_err_o`=0.
  - `csb0_o`=`csb1_o`=1 and `sram_sel_o`=0 during and after reset.
- Reset mid-operation aborts at the next edge; a pending capture is discarded.
- Strobe sampled at edge E1 → macro access at E1 → dout captured at E2 → load accepted at E3 or later → first output bit `sr[111]` is visible on `scan_out_o` in the cycle after the load. Each further bit appears one cycle after the previous one.
- Read-back frame = command frame with din fields replaced by dout.

## Configuration
- `SRAM_SCAN_ERR_EN` defined: `bit_cnt`, the frame checks and `frame_err_o` logic are present as specified.
- Not defined: the counter is removed, every strobe in IDLE/READY executes regardless of frame completeness, out-of-range sel still yields `sram_sel_o=0`, and `frame_err_o` is tied 0.

## Test plan
- Write then read macro 2: shift frame (sel=2, addr0=1, din0=0x0000_0002, csb0=0, web0=0) and strobe; then shift (sel=2, addr0=1, csb0=0, web0=1) and strobe, load, shift out → read-back din0=0x0000_0002, other bits equal to the command.
- Dual-port read of macro 0, with addr0=1 holding 0 and addr1=2 holding 0xFFFF_FFFF → both din fields returned, `sram_sel_o`=0x0001 only during the ACCESS cycle.
- Strobe after only 50 shifted bits → `csb0_o`/`csb1_o` stay 1 and `frame_err_o`=1 (macro defined).
- sel=15 with `NUM_SRAM`=12 → `sram_sel_o`=0, read-back din=0, `frame_err_o`=1.
- Assert `wb_rst_i` during the ACCESS cycle → next cycle is IDLE, all outputs at reset values, subsequent `sram_load_i` is ignored and flagged.
- Without the macro: strobe after 50 bits → access executes and `frame_err_o` stays 0.
